blk_stage3_deser: RTL and testbench

- Downstream neighbour of the stage-2 block; consumes its registered 1-bit `out` stream.
- Packs qualified serial bits LSB-first into WIDTH-bit words.
- Buffers completed words in a DEPTH-entry FIFO and presents them on a valid/ready interface to the capture/readout logic.
- Flags dropped words with a sticky overflow bit.

---
 rtl/blk_pkg.sv | 11 +
 rtl/blk_sync_fifo.sv | 53 +++++
 rtl/blk_stage3_deser.sv | 90 +++++++++
 tb/tb_blk_stage3_deser.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/blk_pkg.sv
// blk_pkg: shared defaults, word type and level-width helper for the stage-3 deserializer.
package blk_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;

    typedef logic [DEF_WIDTH-1:0] word_t;

    function automatic int lvlw(input int depth);
        return $clog2(depth + 1);
    endfunction
endpackage

// File: rtl/blk_sync_fifo.sv
// blk_sync_fifo: register-array FIFO; full/empty come from a level counter, pointers wrap naturally.
module blk_sync_fifo
    import blk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LVLW  = lvlw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [LVLW-1:0]  level
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr, rptr;
    logic             rd, wr;

    assign full  = level == LVLW'(DEPTH);
    assign empty = level == '0;
    assign rd    = pop && !empty;
    // a push into a full FIFO is accepted only when the head leaves on the same edge
    assign wr    = push && (!full || rd);
    assign dout  = mem[rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else if (clr) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (wr) begin
                mem[wptr] <= din;
                wptr      <= wptr + 1'b1;
            end
            if (rd) rptr <= rptr + 1'b1;
            if (wr && !rd) level <= level + 1'b1;
            else if (rd && !wr) level <= level - 1'b1;
        end
    end
endmodule

// File: rtl/blk_stage3_deser.sv
// blk_stage3_deser: LSB-first serial-to-parallel packer feeding a valid/ready FIFO with sticky overflow.
// Define BLK_STAGE3_PARITY_EN to store an even-parity bit per word and expose out_par/par_err.
module blk_stage3_deser
    import blk_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int LVLW  = lvlw(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_bit,
    input  logic             in_en,
    input  logic             flush,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [LVLW-1:0]  level,
    output logic             overflow,
    input  logic             clr_ovf
`ifdef BLK_STAGE3_PARITY_EN
    ,
    output logic             out_par,
    output logic             par_err
`endif
);
    localparam int CW = $clog2(WIDTH);
`ifdef BLK_STAGE3_PARITY_EN
    localparam int FW = WIDTH + 1;
`else
    localparam int FW = WIDTH;
`endif

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sh, word;
    logic [FW-1:0]    din, dout;
    logic             last, done, pop, full, empty;

    always_comb begin
        word      = sh;
        word[cnt] = in_bit;
    end

    assign last      = cnt == CW'(WIDTH - 1);
    assign done      = in_en && last && !flush;
    assign out_valid = !empty;
    assign pop       = out_valid && out_ready && !flush;
    assign out_data  = dout[WIDTH-1:0];

`ifdef BLK_STAGE3_PARITY_EN
    assign din     = {^word, word};
    assign out_par = dout[WIDTH];
    assign par_err = pop && (^dout);
`else
    assign din = word;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sh  <= '0;
        end else if (flush) begin
            cnt <= '0;
            sh  <= '0;
        end else if (in_en) begin
            cnt <= last ? '0 : cnt + 1'b1;
            sh  <= last ? '0 : word;
        end
    end

    // set beats clear when a drop coincides with clr_ovf
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) overflow <= 1'b0;
        else if (done && full && !pop) overflow <= 1'b1;
        else if (clr_ovf) overflow <= 1'b0;
    end

    blk_sync_fifo #(.WIDTH(FW), .DEPTH(DEPTH), .LVLW(LVLW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (flush),
        .push  (done),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .full  (full),
        .empty (empty),
        .level (level)
    );
endmodule

// File: tb/tb_blk_stage3_deser.sv
// tb_blk_stage3_deser: directed vectors with hand-computed words for the stage-3 deserializer.
module tb_blk_stage3_deser;
    logic       clk = 0, rst_n = 0, in_bit = 0, in_en = 0, flush = 0, out_ready = 0, clr_ovf = 0;
    logic [7:0] out_data;
    logic       out_valid, overflow;
    logic [2:0] level;
    int         checks = 0, errors = 0;
`ifdef BLK_STAGE3_PARITY_EN
    logic       out_par, par_err, perr_seen = 0;
`endif

    blk_stage3_deser dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_bit    (in_bit),
        .in_en     (in_en),
        .flush     (flush),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .level     (level),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef BLK_STAGE3_PARITY_EN
        ,
        .out_par   (out_par),
        .par_err   (par_err)
`endif
    );

    always #5 clk = ~clk;

`ifdef BLK_STAGE3_PARITY_EN
    always @(negedge clk) if (par_err) perr_seen = 1;
`endif

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // gaps[i] inserts an idle cycle after bit i; rl drives out_ready on the final bit; ce checks no early word
    task automatic send_word(input logic [7:0] w, input logic [7:0] gaps, input logic rl, input logic ce);
        for (int i = 0; i < 8; i++) begin
            in_en     = 1;
            in_bit    = w[i];
            out_ready = (i == 7) ? rl : 1'b0;
            tick();
            in_en     = 0;
            out_ready = 0;
            if (ce && i < 7) check("no_early_word", out_valid, 0);
            if (gaps[i]) begin
                tick();
                if (ce) check("no_word_in_gap", out_valid, 0);
            end
        end
    endtask

    task automatic pop_one();
        out_ready = 1;
        tick();
        out_ready = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        #23;
        check("rst_valid", out_valid, 0);
        check("rst_level", level, 0);
        check("rst_ovf", overflow, 0);
        check("rst_data", out_data, 0);
        @(negedge clk) rst_n = 1;

        send_word(8'h4D, 8'h00, 0, 1);
        check("basic_valid", out_valid, 1);
        check("basic_data", out_data, 8'h4D);
        check("basic_level", level, 1);
`ifdef BLK_STAGE3_PARITY_EN
        check("basic_par", out_par, 0);
`endif
        pop_one();
        check("basic_popped", out_valid, 0);

        send_word(8'h4D, 8'h12, 0, 1);
        check("gap_data", out_data, 8'h4D);
        check("gap_level", level, 1);
        pop_one();

        for (int k = 1; k <= 4; k++) send_word(8'(k), 8'h00, 0, 0);
        check("fill_level", level, 4);
        check("fill_no_ovf", overflow, 0);
        send_word(8'h05, 8'h00, 0, 0);
        check("ovf_level", level, 4);
        check("ovf_set", overflow, 1);
        for (int k = 1; k <= 4; k++) begin
            check("drain_valid", out_valid, 1);
            check("drain_data", out_data, k);
            pop_one();
        end
        check("drain_empty", out_valid, 0);

        clr_ovf = 1;
        tick();
        clr_ovf = 0;
        check("clr_ovf", overflow, 0);

        for (int k = 0; k < 4; k++) send_word(8'h10 + 8'(k), 8'h00, 0, 0);
        send_word(8'hAA, 8'h00, 1, 0);
        check("fullpop_level", level, 4);
        check("fullpop_no_ovf", overflow, 0);
        check("fullpop_head", out_data, 8'h11);
        for (int k = 0; k < 4; k++) begin
            check("fullpop_data", out_data, (k == 3) ? 8'hAA : 8'h11 + 8'(k));
            pop_one();
        end
        check("fullpop_empty", out_valid, 0);

        for (int k = 0; k < 4; k++) send_word(8'h20 + 8'(k), 8'h00, 0, 0);
        clr_ovf = 1;
        send_word(8'h24, 8'h00, 0, 0);
        clr_ovf = 0;
        check("set_wins", overflow, 1);
        flush = 1;
        tick();
        flush = 0;
        check("flush_keeps_ovf", overflow, 1);
        check("flush_level", level, 0);

        send_word(8'h31, 8'h00, 0, 0);
        send_word(8'h32, 8'h00, 0, 0);
        for (int i = 0; i < 3; i++) begin
            in_en  = 1;
            in_bit = 1;
            tick();
        end
        flush     = 1;
        clr_ovf   = 1;
        out_ready = 1;
        tick();
        flush     = 0;
        clr_ovf   = 0;
        out_ready = 0;
        in_en     = 0;
        check("flush_lvl0", level, 0);
        check("flush_valid0", out_valid, 0);
        check("flush_clr_ovf", overflow, 0);
        send_word(8'h3C, 8'h00, 0, 1);
        check("post_flush_data", out_data, 8'h3C);
        check("post_flush_level", level, 1);

        for (int i = 0; i < 4; i++) begin
            in_en  = 1;
            in_bit = 0;
            tick();
        end
        in_en = 0;
        #2 rst_n = 0;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_level", level, 0);
        check("arst_ovf", overflow, 0);
        @(negedge clk) rst_n = 1;
        send_word(8'hF0, 8'h00, 0, 1);
        check("arst_word_valid", out_valid, 1);
        check("arst_word_data", out_data, 8'hF0);
`ifdef BLK_STAGE3_PARITY_EN
        check("par_err_quiet", perr_seen, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
